// File: rtl/data_path_pkg.sv
// Shared definitions for the single-bus datapath slice: default width,
// bus-source encoding with its fixed priority, and the ALU operation decode.
package data_path_pkg;

    localparam int DP_WIDTH = 32;

    // Bus sources, listed lowest to highest priority.
    typedef enum logic [2:0] {
        BUS_NONE = 3'd0,
        BUS_PC   = 3'd1,
        BUS_R3   = 3'd2,
        BUS_R2   = 3'd3,
        BUS_MDR  = 3'd4,
        BUS_ZLOW = 3'd5
    } bus_src_e;

    // ALU operations; AND wins over increment when both are requested.
    typedef enum logic [1:0] {
        ALU_NONE = 2'd0,
        ALU_AND  = 2'd1,
        ALU_INC  = 2'd2
    } alu_op_e;

    // Resolve overlapping bus selects: Zlow > MDR > R2 > R3 > PC.
    // The sequencer should keep them one-hot; this only makes overlap deterministic.
    function automatic bus_src_e bus_select(
        input logic zlow_out,
        input logic mdr_out,
        input logic r2_out,
        input logic r3_out,
        input logic pc_out
    );
        bus_src_e sel;
        sel = BUS_NONE;
        if (zlow_out) begin
            sel = BUS_ZLOW;
        end else if (mdr_out) begin
            sel = BUS_MDR;
        end else if (r2_out) begin
            sel = BUS_R2;
        end else if (r3_out) begin
            sel = BUS_R3;
        end else if (pc_out) begin
            sel = BUS_PC;
        end
        return sel;
    endfunction

    // Decode the two ALU strobes into a single operation.
    function automatic alu_op_e alu_select(
        input logic and_op,
        input logic inc_op
    );
        alu_op_e op;
        op = ALU_NONE;
        if (and_op) begin
            op = ALU_AND;
        end else if (inc_op) begin
            op = ALU_INC;
        end
        return op;
    endfunction

endpackage

// File: rtl/data_path_dp_reg.sv
// Generic load-enabled register with asynchronous active-high clear.
// Every storage element of the datapath is an instance of this block.
module dp_reg #(
    parameter int W = 32
) (
    input  logic         Clock,
    input  logic         Clear,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Clear dominates; otherwise load d when enabled, else hold.
    always_ff @(posedge Clock or posedge Clear) begin
        if (Clear) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/data_path.sv
// Single-bus CPU datapath slice. All registers share one internal bus driven
// by a priority bus mux; the ALU takes Y as operand A and the bus as operand B
// and writes a double-width result into Z. Every strobe comes from an
// external sequencer, so this block contains no state machine of its own.
module data_path
    import data_path_pkg::*;
#(
    parameter int WIDTH = DP_WIDTH
) (
    input  logic               Clock,
    input  logic               Clear,
    input  logic               PCout,
    input  logic               Zlowout,
    input  logic               MDRout,
    input  logic               R2out,
    input  logic               R3out,
    input  logic               MARin,
    input  logic               Zin,
    input  logic               PCin,
    input  logic               MDRin,
    input  logic               IRin,
    input  logic               Yin,
    input  logic               R1in,
    input  logic               R2in,
    input  logic               R3in,
    input  logic               IncPC,
    input  logic               AND,
    input  logic               Read,
    input  logic [WIDTH-1:0]   Mdatain,
    output logic [WIDTH-1:0]   BusOut,
    output logic [WIDTH-1:0]   PC_q,
    output logic [WIDTH-1:0]   IR_q,
    output logic [WIDTH-1:0]   MAR_q,
    output logic [WIDTH-1:0]   MDR_q,
    output logic [WIDTH-1:0]   Y_q,
    output logic [WIDTH-1:0]   R1_q,
    output logic [WIDTH-1:0]   R2_q,
    output logic [WIDTH-1:0]   R3_q,
    output logic [2*WIDTH-1:0] Z_q
);

    bus_src_e           bus_src;
    alu_op_e            alu_op;
    logic [WIDTH-1:0]   zlow;
    logic [WIDTH-1:0]   mdr_d;
    logic [WIDTH-1:0]   inc_val;
    logic [2*WIDTH-1:0] alu_result;

    // Only the low half of Z can reach the bus; Zhigh is visible on Z_q only.
    assign zlow = Z_q[WIDTH-1:0];

    // Bus mux: pick the highest-priority active source, zero when idle.
    always_comb begin
        bus_src = bus_select(Zlowout, MDRout, R2out, R3out, PCout);
        BusOut  = '0;
        case (bus_src)
            BUS_ZLOW: BusOut = zlow;
            BUS_MDR:  BusOut = MDR_q;
            BUS_R2:   BusOut = R2_q;
            BUS_R3:   BusOut = R3_q;
            BUS_PC:   BusOut = PC_q;
            default:  BusOut = '0;
        endcase
    end

    // ALU: A = Y, B = bus. Increment wraps within WIDTH; the high half is zero.
    always_comb begin
        alu_op     = alu_select(AND, IncPC);
        inc_val    = BusOut + WIDTH'(1);
        alu_result = '0;
        case (alu_op)
            ALU_AND: alu_result = {{WIDTH{1'b0}}, Y_q & BusOut};
            ALU_INC: alu_result = {{WIDTH{1'b0}}, inc_val};
            default: alu_result = '0;
        endcase
    end

    // MDR input select: memory data on a read, otherwise the bus.
    always_comb begin
        mdr_d = Read ? Mdatain : BusOut;
    end

    dp_reg #(.W(WIDTH)) u_pc (
        .Clock (Clock), .Clear (Clear), .en (PCin),  .d (BusOut), .q (PC_q)
    );

    dp_reg #(.W(WIDTH)) u_ir (
        .Clock (Clock), .Clear (Clear), .en (IRin),  .d (BusOut), .q (IR_q)
    );

    dp_reg #(.W(WIDTH)) u_mar (
        .Clock (Clock), .Clear (Clear), .en (MARin), .d (BusOut), .q (MAR_q)
    );

    dp_reg #(.W(WIDTH)) u_mdr (
        .Clock (Clock), .Clear (Clear), .en (MDRin), .d (mdr_d),  .q (MDR_q)
    );

    dp_reg #(.W(WIDTH)) u_y (
        .Clock (Clock), .Clear (Clear), .en (Yin),   .d (BusOut), .q (Y_q)
    );

    dp_reg #(.W(WIDTH)) u_r1 (
        .Clock (Clock), .Clear (Clear), .en (R1in),  .d (BusOut), .q (R1_q)
    );

    dp_reg #(.W(WIDTH)) u_r2 (
        .Clock (Clock), .Clear (Clear), .en (R2in),  .d (BusOut), .q (R2_q)
    );

    dp_reg #(.W(WIDTH)) u_r3 (
        .Clock (Clock), .Clear (Clear), .en (R3in),  .d (BusOut), .q (R3_q)
    );

    dp_reg #(.W(2*WIDTH)) u_z (
        .Clock (Clock), .Clear (Clear), .en (Zin),   .d (alu_result), .q (Z_q)
    );

endmodule

// File: tb/tb_data_path.sv
// Bench for data_path: directed register-transfer sequences followed by
// random control patterns, all compared against a register-level model.
module tb_data_path;

    localparam int W = 32;

    logic          Clock;
    logic          Clear;
    logic          PCout, Zlowout, MDRout, R2out, R3out;
    logic          MARin, Zin, PCin, MDRin, IRin, Yin, R1in, R2in, R3in;
    logic          IncPC, AND, Read;
    logic [W-1:0]  Mdatain;
    logic [W-1:0]  BusOut, PC_q, IR_q, MAR_q, MDR_q, Y_q, R1_q, R2_q, R3_q;
    logic [2*W-1:0] Z_q;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference register contents.
    logic [W-1:0]   pc_m, ir_m, mar_m, mdr_m, y_m, r1_m, r2_m, r3_m;
    logic [2*W-1:0] z_m;

    data_path dut (
        .Clock (Clock), .Clear (Clear),
        .PCout (PCout), .Zlowout (Zlowout), .MDRout (MDRout), .R2out (R2out), .R3out (R3out),
        .MARin (MARin), .Zin (Zin), .PCin (PCin), .MDRin (MDRin), .IRin (IRin), .Yin (Yin),
        .R1in (R1in), .R2in (R2in), .R3in (R3in),
        .IncPC (IncPC), .AND (AND), .Read (Read), .Mdatain (Mdatain),
        .BusOut (BusOut), .PC_q (PC_q), .IR_q (IR_q), .MAR_q (MAR_q), .MDR_q (MDR_q),
        .Y_q (Y_q), .R1_q (R1_q), .R2_q (R2_q), .R3_q (R3_q), .Z_q (Z_q)
    );

    // Clock and reset block
    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic idle();
        PCout = 0; Zlowout = 0; MDRout = 0; R2out = 0; R3out = 0;
        MARin = 0; Zin = 0; PCin = 0; MDRin = 0; IRin = 0; Yin = 0;
        R1in = 0; R2in = 0; R3in = 0; IncPC = 0; AND = 0; Read = 0;
    endtask

    task automatic model_reset();
        pc_m = '0; ir_m = '0; mar_m = '0; mdr_m = '0; y_m = '0;
        r1_m = '0; r2_m = '0; r3_m = '0; z_m = '0;
    endtask

    // Bus value implied by the selects and the modelled register contents.
    function automatic logic [W-1:0] bus_m();
        if (Zlowout)     return z_m[W-1:0];
        else if (MDRout) return mdr_m;
        else if (R2out)  return r2_m;
        else if (R3out)  return r3_m;
        else if (PCout)  return pc_m;
        return '0;
    endfunction

    function automatic logic [2*W-1:0] alu_m(input logic [W-1:0] b);
        logic [W-1:0] sum;
        sum = b + 32'd1;
        if (AND)        return {32'd0, y_m & b};
        else if (IncPC) return {32'd0, sum};
        return '0;
    endfunction

    task automatic chk(input string tag, input logic [2*W-1:0] obs, input logic [2*W-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".bus"}, {32'd0, BusOut}, {32'd0, bus_m()});
        chk({tag, ".pc"},  {32'd0, PC_q},  {32'd0, pc_m});
        chk({tag, ".ir"},  {32'd0, IR_q},  {32'd0, ir_m});
        chk({tag, ".mar"}, {32'd0, MAR_q}, {32'd0, mar_m});
        chk({tag, ".mdr"}, {32'd0, MDR_q}, {32'd0, mdr_m});
        chk({tag, ".y"},   {32'd0, Y_q},   {32'd0, y_m});
        chk({tag, ".r1"},  {32'd0, R1_q},  {32'd0, r1_m});
        chk({tag, ".r2"},  {32'd0, R2_q},  {32'd0, r2_m});
        chk({tag, ".r3"},  {32'd0, R3_q},  {32'd0, r3_m});
        chk({tag, ".z"},   Z_q,            z_m);
    endtask

    // Driver: apply current controls across one rising edge, advance the
    // model, then compare one time unit after the edge.
    task automatic cycle(input string tag);
        logic [W-1:0]   b;
        logic [2*W-1:0] a;
        b = bus_m();
        a = alu_m(b);
        @(posedge Clock);
        if (PCin)  pc_m  = b;
        if (IRin)  ir_m  = b;
        if (MARin) mar_m = b;
        if (MDRin) mdr_m = Read ? Mdatain : b;
        if (Yin)   y_m   = b;
        if (R1in)  r1_m  = b;
        if (R2in)  r2_m  = b;
        if (R3in)  r3_m  = b;
        if (Zin)   z_m   = a;
        #1;
        check_all(tag);
        idle();
    endtask

    initial begin
        logic [W-1:0]   snap [8];
        logic [2*W-1:0] snap_z;

        idle();
        Mdatain = '0;
        Clear   = 1'b1;
        model_reset();
        repeat (2) @(posedge Clock);
        #1;
        check_all("reset");
        Clear = 1'b0;

        // Load R2, R3, R1 through MDR.
        Mdatain = 32'h12; Read = 1; MDRin = 1; cycle("ld_mdr12");
        chk("mdr_0x12", {32'd0, MDR_q}, 64'h12);
        MDRout = 1; R2in = 1; cycle("mdr_to_r2");
        chk("r2_0x12", {32'd0, R2_q}, 64'h12);
        Mdatain = 32'h14; Read = 1; MDRin = 1; cycle("ld_mdr14");
        MDRout = 1; R3in = 1; cycle("mdr_to_r3");
        chk("r3_0x14", {32'd0, R3_q}, 64'h14);
        Mdatain = 32'h18; Read = 1; MDRin = 1; cycle("ld_mdr18");
        MDRout = 1; R1in = 1; cycle("mdr_to_r1");
        chk("r1_0x18", {32'd0, R1_q}, 64'h18);

        // Instruction fetch from PC = 0.
        PCout = 1; MARin = 1; IncPC = 1; Zin = 1; cycle("fetch_t0");
        chk("t0_mar", {32'd0, MAR_q}, 64'h0);
        chk("t0_z", Z_q, 64'h1);
        Zlowout = 1; PCin = 1; Read = 1; MDRin = 1; Mdatain = 32'h2891_8000; cycle("fetch_t1");
        chk("t1_pc", {32'd0, PC_q}, 64'h1);
        chk("t1_mdr", {32'd0, MDR_q}, 64'h2891_8000);
        MDRout = 1; IRin = 1; cycle("fetch_t2");
        chk("t2_ir", {32'd0, IR_q}, 64'h2891_8000);

        // AND R1, R2, R3.
        R2out = 1; Yin = 1; cycle("and_t3");
        chk("and_y", {32'd0, Y_q}, 64'h12);
        R3out = 1; AND = 1; Zin = 1; cycle("and_t4");
        chk("and_z", Z_q, 64'h10);
        Zlowout = 1; R1in = 1; cycle("and_t5");
        chk("and_r1", {32'd0, R1_q}, 64'h10);

        // Bus priority with overlapping selects.
        MDRout = 1; R2out = 1; #1;
        chk("prio_mdr_r2", {32'd0, BusOut}, {32'd0, mdr_m});
        Zlowout = 1; R3out = 1; PCout = 1; #1;
        chk("prio_zlow", {32'd0, BusOut}, {32'd0, z_m[W-1:0]});
        idle(); #1;
        chk("bus_idle", {32'd0, BusOut}, 64'h0);

        // AND beats IncPC: Y = 0x12, bus = R3 = 0x14.
        R3out = 1; AND = 1; IncPC = 1; Zin = 1; cycle("and_over_inc");
        chk("and_over_inc_z", Z_q, 64'h10);

        // Increment wraps at all-ones.
        Mdatain = 32'hFFFF_FFFF; Read = 1; MDRin = 1; cycle("ld_ffff");
        MDRout = 1; PCin = 1; cycle("pc_ffff");
        PCout = 1; IncPC = 1; Zin = 1; cycle("inc_wrap");
        chk("inc_wrap_z", Z_q, 64'h0);

        // PC increments from itself through Zlow.
        Mdatain = 32'h7; Read = 1; MDRin = 1; cycle("ld_7");
        MDRout = 1; PCin = 1; cycle("pc_7");
        PCout = 1; IncPC = 1; Zin = 1; cycle("pc_inc");
        Zlowout = 1; PCin = 1; cycle("pc_self");
        chk("pc_self_8", {32'd0, PC_q}, 64'h8);

        // Hold: no enables while Mdatain toggles and selects wander.
        snap[0] = PC_q; snap[1] = IR_q; snap[2] = MAR_q; snap[3] = MDR_q;
        snap[4] = Y_q;  snap[5] = R1_q; snap[6] = R2_q;  snap[7] = R3_q;
        snap_z  = Z_q;
        for (int i = 0; i < 5; i++) begin
            Mdatain = $urandom;
            Read    = $urandom_range(0, 1);
            PCout   = $urandom_range(0, 1);
            MDRout  = $urandom_range(0, 1);
            cycle("hold");
        end
        chk("hold_pc", {32'd0, PC_q}, {32'd0, snap[0]});
        chk("hold_ir", {32'd0, IR_q}, {32'd0, snap[1]});
        chk("hold_mdr", {32'd0, MDR_q}, {32'd0, snap[3]});
        chk("hold_r1", {32'd0, R1_q}, {32'd0, snap[5]});
        chk("hold_z", Z_q, snap_z);

        // Clear mid-run clears immediately, between edges, and dominates enables.
        @(posedge Clock); #2;
        MDRin = 1; Read = 1; PCout = 1; PCin = 1; Zin = 1; IncPC = 1;
        Clear = 1'b1; #1;
        model_reset();
        idle(); #1;
        check_all("clear_async");
        @(posedge Clock); #1;
        check_all("clear_held");
        Clear = 1'b0;

        // Random control patterns against the model.
        for (int i = 0; i < 300; i++) begin
            Mdatain = $urandom;
            Zlowout = ($urandom_range(0, 5) == 0);
            MDRout  = ($urandom_range(0, 3) == 0);
            R2out   = ($urandom_range(0, 3) == 0);
            R3out   = ($urandom_range(0, 3) == 0);
            PCout   = ($urandom_range(0, 3) == 0);
            MARin   = $urandom_range(0, 1);
            Zin     = $urandom_range(0, 1);
            PCin    = $urandom_range(0, 1);
            MDRin   = $urandom_range(0, 1);
            IRin    = $urandom_range(0, 1);
            Yin     = $urandom_range(0, 1);
            R1in    = $urandom_range(0, 1);
            R2in    = $urandom_range(0, 1);
            R3in    = $urandom_range(0, 1);
            IncPC   = $urandom_range(0, 1);
            AND     = $urandom_range(0, 1);
            Read    = $urandom_range(0, 1);
            cycle("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
